alu_iter: RTL and testbench
===========================

ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter DATA_LEN, default 32, operand/result width (even, >= 8).
REQ-002 Parameter CTRL_LEN, default 4, ALUCtrl width.
REQ-003 clk_i  input  1  single clock, all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  operation request, sampled only in IDLE.
REQ-006 flush_i  input  1  abort current operation (pipeline flush).
REQ-007 ALUCtrl_i  input  CTRL_LEN  op code, sampled with start_i.
REQ-008 data1_i  input  DATA_LEN  signed operand A, sampled with start_i.
REQ-009 data2_i  input  DATA_LEN  signed operand B, sampled with start_i.
REQ-010 busy_o  output  1  high while an operation is in progress (not IDLE).
REQ-011 valid_o  output  1  one-cycle pulse, result available.
REQ-012 data_o  output  DATA_LEN  registered result, held until next valid_o.
REQ-013 Zero_o  output  1  registered, high iff data_o == 0, updated with data_o.

Function
REQ-014 Op codes SHALL be: 0 AND, 1 XOR, 2 SLL, 3 ADD, 4 SUB, 5 MUL, 6 SRAI, 7 OR, 8 DIV, 9 REM; codes 10..2^CTRL_LEN-1 produce result 0.
REQ-015 States SHALL be IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-016 IDLE + start_i with single-cycle op (AND,XOR,SLL,ADD,SUB,SRAI,OR,undefined) -> compute, load data_o, go DONE; valid_o high next cycle (latency 1).
REQ-017 IDLE + start_i with MUL -> MUL state; radix-2 shift-add, one partial product per cycle, exactly DATA_LEN cycles, then DONE; start-to-valid_o latency DATA_LEN+1.
REQ-018 MUL result SHALL be low DATA_LEN bits of signed product (equal to unsigned low product).
REQ-019 IDLE + start_i with DIV/REM -> DIV state; restoring division on magnitudes, one quotient bit per cycle, DATA_LEN cycles, sign fix-up folded into last cycle; latency DATA_LEN+1.
REQ-020 DIV truncates toward zero; REM takes sign of dividend.
REQ-021 Divisor 0: DIV result all-ones, REM result data1_i; latency unchanged.
REQ-022 Overflow (data1_i = most-negative, data2_i = -1): DIV result data1_i, REM result 0.
REQ-023 SLL shift amount SHALL be data2_i[log2(DATA_LEN)-1:0]; SRAI arithmetic, same amount field.
REQ-024 ADD/SUB/MUL wrap modulo 2^DATA_LEN, no overflow flag.
REQ-025 DONE: valid_o = 1 for exactly that cycle, busy_o = 1; next state IDLE unconditionally.
REQ-026 start_i while busy_o = 1 SHALL be ignored (no queueing); operands/op of running operation stay latched.
REQ-027 start_i in IDLE is accepted the same cycle regardless of previous valid_o (back-to-back ops: one idle cycle between DONE and next acceptance).
REQ-028 flush_i in MUL/DIV/DONE -> IDLE next cycle, no valid_o, data_o/Zero_o unchanged; flush_i has priority over start_i in IDLE (start ignored).
REQ-029 Iteration counter SHALL be ceil(log2(DATA_LEN+1)) bits, cleared on every accept.
REQ-030 data_o and Zero_o change only on the cycle entering DONE.

Reset
REQ-031 rst_i low SHALL immediately force IDLE, busy_o=0, valid_o=0, data_o=0, Zero_o=1, counter=0, internal operand registers 0.
REQ-032 Reset mid-MUL/DIV aborts silently; first start_i after rst_i rises is processed normally.

Verification
REQ-033 ADD 7,-3 start at cycle 0 -> valid_o cycle 1, data_o=4, Zero_o=0; SUB 5,5 -> data_o=0, Zero_o=1.
REQ-034 MUL -6,7 (DATA_LEN=32) -> valid_o exactly 33 cycles after start, data_o=0xFFFFFFD6; busy_o high cycles 1..33.
REQ-035 DIV -7,2 -> -3; REM -7,2 -> -1; DIV 5,0 -> 0xFFFFFFFF; REM 5,0 -> 5; DIV 0x80000000,-1 -> 0x80000000, REM -> 0.
REQ-036 start_i DIV, then start_i MUL at cycle 5 -> MUL ignored, DIV result at cycle 33, next MUL accepted only in IDLE.
REQ-037 flush_i at cycle 10 of MUL -> IDLE cycle 11, no valid_o, data_o retains prior value; rst_i low mid-DIV -> outputs at reset values asynchronously.
REQ-038 DATA_LEN=16 build: SLL 1,17 -> amount 1, data_o=2; MUL 300,300 -> 0x5F90, valid_o 17 cycles after start.

Source files
------------

// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle logic/arith ops, radix-2 shift-add multiply,
// restoring signed divide/remainder. One request at a time, flushable.
module alu_iter #(
    parameter int unsigned DATA_LEN = 32,
    parameter int unsigned CTRL_LEN = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                flush_i,
    input  logic [CTRL_LEN-1:0] ALUCtrl_i,
    input  logic [DATA_LEN-1:0] data1_i,
    input  logic [DATA_LEN-1:0] data2_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic [DATA_LEN-1:0] data_o,
    output logic                Zero_o
);

    localparam int unsigned SW = $clog2(DATA_LEN);
    localparam int unsigned CW = $clog2(DATA_LEN + 1);

    localparam logic [CTRL_LEN-1:0] OP_AND = CTRL_LEN'(0);
    localparam logic [CTRL_LEN-1:0] OP_XOR = CTRL_LEN'(1);
    localparam logic [CTRL_LEN-1:0] OP_SLL = CTRL_LEN'(2);
    localparam logic [CTRL_LEN-1:0] OP_ADD = CTRL_LEN'(3);
    localparam logic [CTRL_LEN-1:0] OP_SUB = CTRL_LEN'(4);
    localparam logic [CTRL_LEN-1:0] OP_MUL = CTRL_LEN'(5);
    localparam logic [CTRL_LEN-1:0] OP_SRA = CTRL_LEN'(6);
    localparam logic [CTRL_LEN-1:0] OP_OR  = CTRL_LEN'(7);
    localparam logic [CTRL_LEN-1:0] OP_DIV = CTRL_LEN'(8);
    localparam logic [CTRL_LEN-1:0] OP_REM = CTRL_LEN'(9);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CTRL_LEN-1:0] op_q, op_d;
    logic [DATA_LEN-1:0] a_q, a_d;       // multiplicand / dividend magnitude -> quotient
    logic [DATA_LEN-1:0] b_q, b_d;       // multiplier / divisor magnitude
    logic [DATA_LEN-1:0] acc_q, acc_d;   // partial product
    logic [DATA_LEN-1:0] rem_q, rem_d;   // partial remainder
    logic                neg_quo_q, neg_quo_d;
    logic                neg_rem_q, neg_rem_d;
    logic                div_zero_q, div_zero_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic                zero_q, zero_d;
    logic                busy_q, valid_q;

    logic [DATA_LEN-1:0] alu_res;
    logic [DATA_LEN-1:0] abs1, abs2;
    logic [DATA_LEN-1:0] mul_acc;
    logic [DATA_LEN:0]   rem_sh, rem_diff;
    logic                q_bit;
    logic [DATA_LEN-1:0] rem_next, quo_next, div_res;
    logic                last_iter;

    // Single-cycle operation result, straight from the request operands
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND: alu_res = data1_i & data2_i;
            OP_XOR: alu_res = data1_i ^ data2_i;
            OP_SLL: alu_res = data1_i << data2_i[SW-1:0];
            OP_ADD: alu_res = data1_i + data2_i;
            OP_SUB: alu_res = data1_i - data2_i;
            OP_SRA: alu_res = DATA_LEN'($signed(data1_i) >>> data2_i[SW-1:0]);
            OP_OR:  alu_res = data1_i | data2_i;
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes; most-negative maps to 2^(DATA_LEN-1), still fits unsigned
    assign abs1 = data1_i[DATA_LEN-1] ? (-data1_i) : data1_i;
    assign abs2 = data2_i[DATA_LEN-1] ? (-data2_i) : data2_i;

    // One multiply step: add shifted multiplicand when current multiplier bit set
    assign mul_acc = acc_q + (b_q[0] ? a_q : '0);

    // One restoring divide step
    assign rem_sh   = {rem_q, a_q[DATA_LEN-1]};
    assign rem_diff = rem_sh - {1'b0, b_q};
    assign q_bit    = ~rem_diff[DATA_LEN];
    assign rem_next = q_bit ? rem_diff[DATA_LEN-1:0] : rem_sh[DATA_LEN-1:0];
    assign quo_next = {a_q[DATA_LEN-2:0], q_bit};

    // Sign fix-up on the final step; divide-by-zero quotient forced to all-ones
    always_comb begin
        div_res = '0;
        if (op_q == OP_REM) begin
            div_res = neg_rem_q ? (-rem_next) : rem_next;
        end else if (div_zero_q) begin
            div_res = '1;
        end else begin
            div_res = neg_quo_q ? (-quo_next) : quo_next;
        end
    end

    assign last_iter = (cnt_q == CW'(DATA_LEN - 1));

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        rem_d      = rem_q;
        neg_quo_d  = neg_quo_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        data_d     = data_q;
        zero_d     = zero_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    op_d  = ALUCtrl_i;
                    cnt_d = '0;
                    acc_d = '0;
                    rem_d = '0;
                    if (ALUCtrl_i == OP_MUL) begin
                        a_d     = data1_i;
                        b_d     = data2_i;
                        state_d = S_MUL;
                    end else if (ALUCtrl_i == OP_DIV || ALUCtrl_i == OP_REM) begin
                        a_d        = abs1;
                        b_d        = abs2;
                        neg_quo_d  = data1_i[DATA_LEN-1] ^ data2_i[DATA_LEN-1];
                        neg_rem_d  = data1_i[DATA_LEN-1];
                        div_zero_d = (data2_i == '0);
                        state_d    = S_DIV;
                    end else begin
                        a_d     = data1_i;
                        b_d     = data2_i;
                        data_d  = alu_res;
                        zero_d  = (alu_res == '0);
                        state_d = S_DONE;
                    end
                end
            end
            S_MUL: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = mul_acc;
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        data_d  = mul_acc;
                        zero_d  = (mul_acc == '0);
                        state_d = S_DONE;
                    end
                end
            end
            S_DIV: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_next;
                    a_d   = quo_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        data_d  = div_res;
                        zero_d  = (div_res == '0);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            rem_q      <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            data_q     <= '0;
            zero_q     <= 1'b1;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            rem_q      <= rem_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            data_q     <= data_d;
            zero_q     <= zero_d;
            busy_q     <= (state_d != S_IDLE);
            valid_q    <= (state_d == S_DONE);
        end
    end

    assign busy_o  = busy_q;
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign Zero_o  = zero_q;

endmodule

// File: tb/tb_alu_iter.sv
// Randomized and directed bench for alu_iter (32-bit plus a 16-bit build).
module tb_alu_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush;
    logic [3:0]  ctrl;
    logic [31:0] d1, d2;
    logic        busy, valid, zero;
    logic [31:0] dout;

    logic        start16, flush16;
    logic [3:0]  ctrl16;
    logic [15:0] a16, b16;
    logic        busy16, valid16, zero16;
    logic [15:0] dout16;

    int checks   = 0;
    int failures = 0;
    logic [31:0] last_res;

    always #5 clk = ~clk;

    alu_iter dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .flush_i(flush),
        .ALUCtrl_i(ctrl), .data1_i(d1), .data2_i(d2),
        .busy_o(busy), .valid_o(valid), .data_o(dout), .Zero_o(zero)
    );

    alu_iter #(.DATA_LEN(16), .CTRL_LEN(4)) dut16 (
        .clk_i(clk), .rst_i(rst_n), .start_i(start16), .flush_i(flush16),
        .ALUCtrl_i(ctrl16), .data1_i(a16), .data2_i(b16),
        .busy_o(busy16), .valid_o(valid16), .data_o(dout16), .Zero_o(zero16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers, truncated to 32 bits
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        logic [31:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0: r = a & b;
            4'd1: r = a ^ b;
            4'd2: r = a << b[4:0];
            4'd3: r = 32'(sa + sb);
            4'd4: r = 32'(sa - sb);
            4'd5: r = 32'(sa * sb);
            4'd6: r = 32'($signed(a) >>> b[4:0]);
            4'd7: r = a | b;
            4'd8: r = (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            4'd9: r = (b == 32'd0) ? a : 32'(sa % sb);
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input logic [3:0] op);
        return (op == 4'd5 || op == 4'd8 || op == 4'd9) ? 33 : 1;
    endfunction

    // Issue one op from IDLE, scramble inputs after acceptance, check result and timing
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int cyc;
        bit busy_ok;
        ctrl = op; d1 = a; d2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; d1 = $urandom; d2 = $urandom; ctrl = 4'($urandom);
        cyc = 1; busy_ok = 1'b1;
        while (!valid && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, ".valid"}, 64'(valid), 64'd1);
        check({tag, ".busy_run"}, 64'(busy_ok & busy), 64'd1);
        check({tag, ".data"}, 64'(dout), 64'(exp));
        check({tag, ".zero"}, 64'(zero), 64'(exp == 32'd0));
        @(posedge clk); #1;
        check({tag, ".valid_drop"}, 64'(valid), 64'd0);
        check({tag, ".idle"}, 64'(busy), 64'd0);
        check({tag, ".hold"}, 64'(dout), 64'(exp));
        last_res = exp;
    endtask

    task automatic run16(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp, input int exp_lat);
        int cyc;
        ctrl16 = op; a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        cyc = 1;
        while (!valid16 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, ".lat"}, 64'(cyc), 64'(exp_lat));
        check({tag, ".data"}, 64'(dout16), 64'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;
        int cyc;
        bit seen;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; ctrl = '0; d1 = '0; d2 = '0;
        start16 = 1'b0; flush16 = 1'b0; ctrl16 = '0; a16 = '0; b16 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.valid", 64'(valid), 64'd0);
        check("rst.data", 64'(dout), 64'd0);
        check("rst.zero", 64'(zero), 64'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed values
        run_op("add", 4'd3, 32'd7, 32'hFFFF_FFFD, 32'd4, 1);
        run_op("sub0", 4'd4, 32'd5, 32'd5, 32'd0, 1);
        run_op("mul", 4'd5, 32'hFFFF_FFFA, 32'd7, 32'hFFFF_FFD6, 33);
        run_op("div", 4'd8, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem", 4'd9, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div0", 4'd8, 32'd5, 32'd0, 32'hFFFF_FFFF, 33);
        run_op("rem0", 4'd9, 32'd5, 32'd0, 32'd5, 33);
        run_op("divovf", 4'd8, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
        run_op("removf", 4'd9, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
        run_op("sll", 4'd2, 32'd1, 32'd33, 32'd2, 1);
        run_op("srai", 4'd6, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
        run_op("undef", 4'd12, 32'd9, 32'd3, 32'd0, 1);

        // Randomized ops with corner-biased operands
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($signed($urandom_range(0, 40)) - 20); b = 32'($signed($urandom_range(0, 10)) - 5); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            run_op("rand", op, a, b, ref_result(op, a, b), ref_latency(op));
        end

        // start while busy is ignored: DIV runs, MUL at cycle 5 dropped
        ctrl = 4'd8; d1 = 32'hFFFF_FFF9; d2 = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; cyc = 1;
        while (!valid && cyc < 100) begin
            if (cyc == 4) begin
                start = 1'b1; ctrl = 4'd5; d1 = 32'd3; d2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        check("ign.lat", 64'(cyc), 64'd33);
        check("ign.data", 64'(dout), 64'hFFFF_FFFD);
        @(posedge clk); #1;
        check("ign.idle", 64'(busy), 64'd0);
        run_op("ign.mul", 4'd5, 32'd3, 32'd3, 32'd9, 33);

        // Flush at cycle 10 of MUL: idle next cycle, no result
        ctrl = 4'd5; d1 = 32'd11; d2 = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush.busy", 64'(busy), 64'd0);
        check("flush.valid", 64'(valid), 64'd0);
        check("flush.data", 64'(dout), 64'(last_res));
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) seen = 1'b1;
        end
        check("flush.novalid", 64'(seen), 64'd0);

        // Flush beats start in IDLE
        ctrl = 4'd3; d1 = 32'd1; d2 = 32'd1; start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flushidle.busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("flushidle.valid", 64'(valid), 64'd0);
        check("flushidle.data", 64'(dout), 64'(last_res));

        // Asynchronous reset mid-DIV
        ctrl = 4'd8; d1 = 32'd100; d2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        check("arst.busy", 64'(busy), 64'd0);
        check("arst.valid", 64'(valid), 64'd0);
        check("arst.data", 64'(dout), 64'd0);
        check("arst.zero", 64'(zero), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 4'd8, 32'd100, 32'd7, 32'd14, 33);

        // 16-bit build
        run16("w16.sll", 4'd2, 16'd1, 16'd17, 16'd2, 1);
        run16("w16.mul", 4'd5, 16'd300, 16'd300, 16'h5F90, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
